// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, stage tags, limits.
package pipe_pkg;

   localparam int MAX_MEM_LAT = 4;
   localparam int TAG_RA_W    = 8;   // widest register address a tag can carry
   localparam int CNT_W       = $clog2(MAX_MEM_LAT);

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_ME  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic                valid;
      logic [TAG_RA_W-1:0] rd;
      logic                we;
      logic                load;
   } stage_tag_t;

   function automatic logic tag_live(input stage_tag_t t);
      return t.valid & t.we & (t.rd != '0);
   endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand forward select for one EX source port: ME result first, then the writeback bus.
module pipe_fwd_sel
   import pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] rs,
   input  logic            rs_used,
   input  stage_tag_t      me_tag,
   input  stage_tag_t      wb_tag,
   output logic [1:0]      sel
);

   logic [TAG_RA_W-1:0] rs_w;
   logic                unused_wb_load;
   fwd_sel_e            sel_e;

   assign rs_w           = TAG_RA_W'(rs);
   assign unused_wb_load = wb_tag.load;

   // A load in ME has no data yet, so it can only be picked up from WB.
   always_comb begin
      sel_e = FWD_REG;
      if (rs_used && tag_live(me_tag) && !me_tag.load && (me_tag.rd == rs_w)) begin
         sel_e = FWD_ME;
      end else if (rs_used && tag_live(wb_tag) && (wb_tag.rd == rs_w)) begin
         sel_e = FWD_WB;
      end
   end

   assign sel = sel_e;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding, load-use stall, flush, memory freeze.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int RA_W    = 5,
   parameter int NRD     = 2,
   parameter int MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [NRD*RA_W-1:0] id_rs,
   input  logic [NRD-1:0]      id_rs_used,
   input  logic [RA_W-1:0]     id_rd,
   input  logic                id_we,
   input  logic                id_load,
   input  logic                ex_branch_taken,
   output logic                stall,
   output logic                flush,
   output logic                mem_busy,
   output logic [2*NRD-1:0]    fwd_sel
);

   stage_tag_t          ex_tag_q, ex_tag_d;
   stage_tag_t          me_tag_q, me_tag_d;
   stage_tag_t          wb_tag_q, wb_tag_d;
   stage_tag_t          id_tag;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                frozen;
   logic                hazard;
   logic                stall_int;
   logic                flush_int;
   logic                take_id;
   logic [TAG_RA_W-1:0] id_src [NRD];
   logic [NRD-1:0]      hit_ex;

   assign frozen = (cnt_q != '0);
   assign id_tag = '{valid: id_valid, rd: TAG_RA_W'(id_rd), we: id_we, load: id_load};

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_src
         assign id_src[gi] = TAG_RA_W'(id_rs[gi*RA_W +: RA_W]);
         assign hit_ex[gi] = id_valid & id_rs_used[gi] & tag_live(ex_tag_q)
                             & (ex_tag_q.rd == id_src[gi]);
      end
   endgenerate

`ifdef PIPE_FWD_EN
   logic [NRD*RA_W-1:0] ex_rs_q, ex_rs_d;
   logic [NRD-1:0]      ex_rs_used_q, ex_rs_used_d;

   // With forwarding, only a load one stage ahead cannot be bypassed in time.
   assign hazard = (|hit_ex) & ex_tag_q.load;

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_fwd
         pipe_fwd_sel #(
            .RA_W (RA_W)
         ) u_fwd_sel (
            .rs      (ex_rs_q[gi*RA_W +: RA_W]),
            .rs_used (ex_rs_used_q[gi]),
            .me_tag  (me_tag_q),
            .wb_tag  (wb_tag_q),
            .sel     (fwd_sel[2*gi +: 2])
         );
      end
   endgenerate

   always_comb begin
      ex_rs_d      = ex_rs_q;
      ex_rs_used_d = ex_rs_used_q;
      if (!frozen) begin
         ex_rs_d      = take_id ? id_rs : '0;
         ex_rs_used_d = take_id ? id_rs_used : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rs_q      <= '0;
         ex_rs_used_q <= '0;
      end else begin
         ex_rs_q      <= ex_rs_d;
         ex_rs_used_q <= ex_rs_used_d;
      end
   end
`else
   logic [NRD-1:0] hit_me, hit_wb;
   logic           unused_load_bits;

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_nofwd
         assign hit_me[gi] = id_valid & id_rs_used[gi] & tag_live(me_tag_q)
                             & (me_tag_q.rd == id_src[gi]);
         assign hit_wb[gi] = id_valid & id_rs_used[gi] & tag_live(wb_tag_q)
                             & (wb_tag_q.rd == id_src[gi]);
      end
   endgenerate

   assign hazard           = |(hit_ex | hit_me | hit_wb);
   assign fwd_sel          = '0;
   assign unused_load_bits = me_tag_q.load ^ wb_tag_q.load;
`endif

   assign flush_int = ex_branch_taken & ~frozen;
   assign stall_int = frozen | (hazard & ~flush_int);
   assign take_id   = ~stall_int & ~flush_int;

   // Outputs are held quiet for the whole reset, even against a live branch input.
   assign stall    = stall_int & ~rst;
   assign flush    = flush_int & ~rst;
   assign mem_busy = frozen & ~rst;

   always_comb begin
      ex_tag_d = ex_tag_q;
      me_tag_d = me_tag_q;
      wb_tag_d = wb_tag_q;
      cnt_d    = cnt_q;
      if (frozen) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         wb_tag_d = me_tag_q;
         me_tag_d = ex_tag_q;
         if (take_id) begin
            ex_tag_d = id_tag;
         end else begin
            ex_tag_d = '0;
         end
         if ((MEM_LAT > 1) && tag_live(ex_tag_q) && ex_tag_q.load) begin
            cnt_d = CNT_W'(MEM_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_tag_q <= '0;
         me_tag_q <= '0;
         wb_tag_q <= '0;
         cnt_q    <= '0;
      end else begin
         ex_tag_q <= ex_tag_d;
         me_tag_q <= me_tag_d;
         wb_tag_q <= wb_tag_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard controller for the five-stage pipeline datapath. It mirrors the ID/EX, EX/MEM and MEM/WB register destinations in an internal tag pipeline, and from those tags produces the signals the datapath needs:
- per-source-port forwarding selects for the EX-stage operand muxes;
- load-use stalls;
- taken-branch flushes;
- a pipeline freeze while a multi-cycle data-memory load completes.

It generalises the existing two-port forwarding logic to N read ports, configurable register-address width and configurable memory latency.

## Interface
Parameters:
- RA_W, 5, register address width
- NRD, 2, source read ports per instruction (1..3)
- MEM_LAT, 1, data-memory load latency in cycles (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NRD*RA_W  ID source register numbers; port k occupies bits [k*RA_W +: RA_W]
- id_rs_used  in  NRD  source port k is actually read
- id_rd  in  RA_W  ID destination register
- id_we  in  1  ID instruction writes the register file
- id_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- flush  out  1  clear IF/ID and ID/EX
- mem_busy  out  1  freeze all pipeline registers
- fwd_sel  out  2*NRD  per-port EX operand select; port k occupies bits [2k +: 2]

## Operation
- Tags:
  - EX tag: valid, rd, we, load, rs[NRD], rs_used[NRD].
  - ME tag and WB tag: valid, rd, we, load.
  - A producer is "live" when valid & we & rd != 0.
- Forwarding (per port k of the EX tag):
  - 2'b10 (EX/MEM result) when the ME tag is a live non-load producer with rd == rs[k] and rs_used[k].
  - Otherwise 2'b01 (writeback bus) when the WB tag is a live producer matching rs[k].
  - Otherwise 2'b00 (register file).
  - ME has priority over WB.
- Load-use stall: stall = 1 when the EX tag is a live load and its rd equals any used ID source, with id_valid = 1.
- Flush: flush = ex_branch_taken & ~mem_busy.
  - Flush overrides stall: when both conditions hold, stall = 0.
- Memory freeze: when a live load enters ME and MEM_LAT > 1, a counter loads MEM_LAT-1.
  - While the counter is nonzero: mem_busy = 1, stall = 1, flush = 0, all tags hold, and the counter decrements each cycle.
- Tag advance when not frozen:
  - WB ← ME, ME ← EX.
  - EX ← bubble (valid = 0) on stall or flush.
  - Otherwise EX ← ID inputs, with valid = id_valid.
- Register 0 is never forwarded and never causes a stall.

## Timing
- stall, flush and fwd_sel are combinational from the tags and ID inputs in the same cycle. Tags and the counter are registered.
- Load-use stall lasts exactly 1 cycle. The consumer then receives fwd_sel = 01 in EX.
- A MEM_LAT = L load asserts mem_busy for L-1 consecutive cycles, beginning the cycle after it enters ME.
- Reset (asserted at any time, including mid-freeze) clears all tags and the counter immediately.
  - stall, flush, mem_busy = 0 and fwd_sel = 0 throughout reset.
  - The first instruction is accepted on the first rising edge after rst deasserts.
- A stall and a WB write to the same register in the same cycle do not interact. Write-through is the register file's responsibility.

## Configuration
- PIPE_FWD_EN defined:
  - Forwarding as described above.
  - Only load-use RAW hazards stall.
- PIPE_FWD_EN undefined:
  - fwd_sel is constant 0.
  - stall = 1 whenever any used ID source matches a live producer in the EX, ME or WB tag.
  - The memory freeze and flush behaviour are unchanged.

## Structure
- pipe_pkg holds:
  - fwd_sel_e: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_ME = 2'b10.
  - stage_tag_t struct, parametrised by RA_W through package localparams.
  - MAX_MEM_LAT = 4.
- Sub-module pipe_fwd_sel: one port's ME/WB compare and priority. Instantiate it NRD times in a generate loop.

## Test plan
All scenarios use RA_W = 5 and NRD = 2 unless stated.
1. add r3 followed immediately by add r4,r3,r1 → on the second instruction's EX cycle, fwd_sel[1:0] = 2'b10, stall = 0.
2. add r3, then a nop, then a consumer of r3 on port 1 → fwd_sel[3:2] = 2'b01.
3. lw r5, then add r6,r5,r1 with MEM_LAT = 1 → stall = 1 for exactly 1 cycle, then the consumer's fwd_sel[1:0] = 2'b01.
4. MEM_LAT = 3, lw r7 → mem_busy = 1 for 2 cycles; tags unchanged across the freeze.
5. Load-use on r5 plus ex_branch_taken in the same cycle → flush = 1, stall = 0, EX tag becomes a bubble. A producer with rd = r0 never forwards or stalls.
6. rst asserted during a MEM_LAT = 4 freeze → mem_busy and stall drop to 0 immediately. Without PIPE_FWD_EN, a producer 2 stages ahead stalls the consumer.
